// File: rtl/pixel_word_packer.sv
// Packs a narrow pixel stream into DATA_WIDTH-bit words for the frame buffer write port.
// Frames are bounded by sof/eof and a fixed word budget; framing faults raise a sticky flag.
module pixel_word_packer #(
  parameter int unsigned PIX_WIDTH       = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_FRAME = 6,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  sof,
  input  logic                  eof,
  input  logic                  pix_valid,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_en_out_l,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int unsigned Ppw   = DATA_WIDTH / PIX_WIDTH;
  localparam int unsigned LaneW = $clog2(Ppw + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPack  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [LaneW-1:0]      lane_q, lane_d;
  logic [CNT_WIDTH-1:0]  word_q, word_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_l_q, wr_l_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  // Set once any frame has completed; gates overrun detection in idle.
  logic                  cmpl_q, cmpl_d;

  logic [DATA_WIDTH-1:0] packed_w;
  logic [LaneW-1:0]      lane_inc;
  logic [CNT_WIDTH-1:0]  word_inc;
  logic                  full;
  logic                  emit;

  always_comb begin
    packed_w = buf_q;
    for (int k = 0; k < Ppw; k++) begin
      if (pix_valid && (lane_q == LaneW'(k))) begin
        packed_w[k*PIX_WIDTH +: PIX_WIDTH] = pix_data;
      end
    end
    lane_inc = lane_q + LaneW'(pix_valid);
    full     = pix_valid && (lane_inc == LaneW'(Ppw));
    emit     = full || (eof && (lane_inc != '0));
    word_inc = word_q + CNT_WIDTH'(emit);
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    buf_d   = buf_q;
    data_d  = data_q;
    wr_l_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = err_q;
    cmpl_d  = cmpl_q;

    case (state_q)
      StPack: begin
        if (sof && !eof) begin
          // Restart: drop the partial word, keep the error visible for the new frame.
          state_d = StPack;
          err_d   = 1'b1;
          word_d  = '0;
          buf_d   = pix_valid ? DATA_WIDTH'(pix_data) : '0;
          lane_d  = pix_valid ? LaneW'(1) : '0;
        end else begin
          buf_d  = packed_w;
          lane_d = lane_inc;
          word_d = word_inc;
          if (emit) begin
            data_d = packed_w;
            wr_l_d = 1'b0;
            buf_d  = '0;
            lane_d = '0;
          end
          if (eof || (word_inc == CNT_WIDTH'(WORDS_PER_FRAME))) begin
            done_d  = 1'b1;
            cmpl_d  = 1'b1;
            state_d = (emit && !full) ? StFlush : StIdle;
            if (word_inc < CNT_WIDTH'(WORDS_PER_FRAME)) begin
              err_d = 1'b1;
            end
            // sof coincident with eof opens the next frame straight away.
            if (sof) begin
              state_d = StPack;
              word_d  = '0;
              err_d   = 1'b0;
              cmpl_d  = 1'b0;
            end
          end
        end
      end
      default: begin
        // Idle, and the cycle in which a flushed partial word is presented.
        state_d = StIdle;
        if (sof) begin
          state_d = StPack;
          word_d  = '0;
          err_d   = 1'b0;
          cmpl_d  = 1'b0;
          buf_d   = pix_valid ? DATA_WIDTH'(pix_data) : '0;
          lane_d  = pix_valid ? LaneW'(1) : '0;
        end else if (pix_valid && cmpl_q) begin
          err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state_q <= StIdle;
      lane_q  <= '0;
      word_q  <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      wr_l_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cmpl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      wr_l_q  <= wr_l_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cmpl_q  <= cmpl_d;
    end
  end

  assign data_out    = data_q;
  assign wr_en_out_l = wr_l_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Scoreboard bench for pixel_word_packer: directed frames push expected strobes/done pulses,
// a negedge monitor pops and compares every write strobe or frame_done it observes.
module tb_pixel_word_packer;

  logic        wr_clk;
  logic        reset;
  logic        sof;
  logic        eof;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [31:0] data_out;
  logic        wr_en_out_l;
  logic        frame_done;
  logic        frame_err;

  pixel_word_packer #(
    .PIX_WIDTH      (8),
    .DATA_WIDTH     (32),
    .WORDS_PER_FRAME(6),
    .CNT_WIDTH      (8)
  ) dut (
    .wr_clk     (wr_clk),
    .reset      (reset),
    .sof        (sof),
    .eof        (eof),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .data_out   (data_out),
    .wr_en_out_l(wr_en_out_l),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        done;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc;
  int          n_tests;
  int          n_fail;

  logic [31:0] words [6];

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  initial cyc = 0;
  always @(posedge wr_clk) cyc <= cyc + 1;

  // Monitor: every strobe or done pulse must match the head of the scoreboard.
  always @(negedge wr_clk) begin
    if (!reset && (!wr_en_out_l || frame_done)) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: cyc=%0d wr_l=%b data=%h done=%b, required no output",
                 cyc, wr_en_out_l, data_out, frame_done);
      end else begin
        mon_e = sb_q.pop_front();
        if ((wr_en_out_l !== ~mon_e.wr) || (mon_e.wr && (data_out !== mon_e.data)) ||
            (frame_done !== mon_e.done) || (cyc != mon_e.cyc)) begin
          n_fail++;
          $display("FAIL strobe: got cyc=%0d wr_l=%b data=%h done=%b, required cyc=%0d wr_l=%b data=%h done=%b",
                   cyc, wr_en_out_l, data_out, frame_done,
                   mon_e.cyc, ~mon_e.wr, mon_e.data, mon_e.done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Expected output appears in the cycle after the one currently being driven.
  task automatic push(input logic wr, input logic [31:0] data, input logic done);
    exp_t e;
    e.wr   = wr;
    e.data = data;
    e.done = done;
    e.cyc  = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic s, input logic e, input logic v, input logic [7:0] p);
    sof       = s;
    eof       = e;
    pix_valid = v;
    pix_data  = p;
    @(posedge wr_clk);
    #1;
    sof       = 1'b0;
    eof       = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Full 24-pixel frame, sof with the first pixel; w0 supplies the first four pixels.
  task automatic run_frame(input logic [31:0] w0);
    logic [7:0] p;
    for (int i = 0; i < 24; i++) begin
      p = (i < 4) ? w0[i*8 +: 8] : 8'(i);
      if (i % 4 == 3) push(1'b1, (i == 3) ? w0 : words[i/4], i == 23);
      drive(i == 0, 1'b0, 1'b1, p);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    words     = '{32'h03020100, 32'h07060504, 32'h0B0A0908,
                  32'h0F0E0D0C, 32'h13121110, 32'h17161514};
    reset     = 1'b1;
    sof       = 1'b0;
    eof       = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    repeat (3) @(posedge wr_clk);
    #1;
    reset = 1'b0;
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_wr_en_l", 32'(wr_en_out_l), 32'h1);
    chk("reset_frame_done", 32'(frame_done), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    idle(2);

    // Full frame of pixels 0x00..0x17.
    run_frame(32'h03020100);
    chk("full_frame_err", 32'(frame_err), 32'h0);
    idle(3);

    // Short frame: gapped pixels then eof carrying the last pixel.
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'hA1);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 8'hB2);
    idle(1);
    push(1'b1, 32'h00C3B2A1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 8'hC3);
    chk("short_frame_err", 32'(frame_err), 32'h1);
    idle(2);

    // Restart: one word, two orphan pixels, then sof with 0x55.
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h10);
    drive(1'b0, 1'b0, 1'b1, 8'h11);
    drive(1'b0, 1'b0, 1'b1, 8'h12);
    push(1'b1, 32'h13121110, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h13);
    drive(1'b0, 1'b0, 1'b1, 8'h20);
    drive(1'b0, 1'b0, 1'b1, 8'h21);
    drive(1'b1, 1'b0, 1'b1, 8'h55);
    chk("restart_err", 32'(frame_err), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 8'h66);
    drive(1'b0, 1'b0, 1'b1, 8'h77);
    push(1'b1, 32'h88776655, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h88);
    push(1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk("restart_eof_err", 32'(frame_err), 32'h1);
    idle(2);

    // Overrun after a complete frame, then sof clears the flag.
    run_frame(32'h03020100);
    chk("frame_before_overrun_err", 32'(frame_err), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 8'hE0);
    drive(1'b0, 1'b0, 1'b1, 8'hE1);
    drive(1'b0, 1'b0, 1'b1, 8'hE2);
    chk("overrun_err", 32'(frame_err), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk("sof_clears_err", 32'(frame_err), 32'h0);

    // Two words and two pixels into this frame, then reset.
    for (int i = 0; i < 10; i++) begin
      if (i % 4 == 3) push(1'b1, words[i/4], 1'b0);
      drive(1'b0, 1'b0, 1'b1, 8'(i));
    end
    reset = 1'b1;
    @(posedge wr_clk);
    #1;
    reset = 1'b0;
    chk("midreset_data_out", data_out, 32'h0);
    chk("midreset_wr_en_l", 32'(wr_en_out_l), 32'h1);
    chk("midreset_frame_done", 32'(frame_done), 32'h0);
    chk("midreset_frame_err", 32'(frame_err), 32'h0);
    idle(5);

    // sof carrying pixel 0x11; a full budget must follow, proving the count restarted.
    run_frame(32'h44332211);
    chk("post_reset_frame_err", 32'(frame_err), 32'h0);

    idle(4);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
